// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: instruction width, NOP encoding, default reset PC, FSM states.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package fetch_stage_pkg;

  localparam int INST_WIDTH = 32;

  // Canonical NOP (addi x0, x0, 0); shown on o_id_inst while IF/ID is empty after reset.
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // An all-zero word marks the end of the program image.
  function automatic logic is_end_word(input logic [INST_WIDTH-1:0] word);
    return (word == '0);
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection: redirect target (word aligned), sequential pc+4, or hold.
// Latency: purely combinational, result is registered by the parent.
// Backpressure: the parent deasserts i_step while stalled or halted so the PC holds.
module fetch_pc_gen #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_step,
  output logic [XLEN-1:0] o_pc_next,
  output logic [XLEN-1:0] o_pc_plus4
);

  logic [XLEN-1:0] redirect_aligned;

  // Sequential successor (wraps mod 2^XLEN) and redirect target with the low two bits cleared.
  always_comb begin
    o_pc_plus4       = i_pc + XLEN'(4);
    redirect_aligned = i_redirect_pc & ~XLEN'(3);
  end

  // Redirect beats sequential advance, which beats hold.
  always_comb begin
    if (i_redirect) begin
      o_pc_next = redirect_aligned;
    end else if (i_step) begin
      o_pc_next = o_pc_plus4;
    end else begin
      o_pc_next = i_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads instruction memory combinationally, fills the IF/ID register.
// Latency: the word at pc appears on o_id_inst one clock edge after it is addressed.
// Backpressure: o_id_valid && !i_id_ready stalls; pc and IF/ID hold until decode accepts.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               MEM_SIZE = 1024,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC),
  localparam int              ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic [ADDR_W-1:0]     o_imem_addr,
  input  logic [INST_WIDTH-1:0] i_imem_inst,
  input  logic                  i_redirect,
  input  logic [XLEN-1:0]       i_redirect_pc,
  input  logic                  i_id_ready,
  output logic                  o_id_valid,
  output logic [INST_WIDTH-1:0] o_id_inst,
  output logic [XLEN-1:0]       o_id_pc,
  output logic [XLEN-1:0]       o_id_pc_plus4,
  output logic                  o_halted
);

  fetch_state_e          state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d, pc_plus4;
  logic                  id_vld_q, id_vld_d;
  logic [INST_WIDTH-1:0] id_inst_q, id_inst_d;
  logic [XLEN-1:0]       id_pc_q, id_pc_d;
  logic [XLEN-1:0]       id_pc_plus4_q, id_pc_plus4_d;

  logic fetch_run;
  logic advance;
  logic word_end;
  logic pc_step;

  // Memory is byte addressed; the fetch address is simply the truncated PC, so fetch wraps.
  assign o_imem_addr = pc_q[ADDR_W-1:0];

  // Fetch proceeds when running and IF/ID is empty or being drained this cycle.
  always_comb begin
    advance  = fetch_run && (!id_vld_q || i_id_ready);
    word_end = is_end_word(i_imem_inst);
    pc_step  = advance && !word_end;
  end

  fetch_pc_gen #(
    .XLEN (XLEN)
  ) u_pc_gen (
    .i_pc          (pc_q),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_step        (pc_step),
    .o_pc_next     (pc_d),
    .o_pc_plus4    (pc_plus4)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a fetched end word halts, a redirect always restarts fetch.
  always_comb begin
    state_d = state_q;
    if (i_redirect) begin
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && advance && word_end) begin
      state_d = ST_HALT;
    end
  end

  // FSM outputs.
  always_comb begin
    fetch_run = (state_q == ST_RUN);
    o_halted  = (state_q == ST_HALT);
  end

  // IF/ID next contents: flush on redirect, load on advance, drain in halt, otherwise hold.
  always_comb begin
    id_vld_d      = id_vld_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    if (i_redirect) begin
      id_vld_d = 1'b0;
    end else if (advance) begin
      if (!word_end) begin
        id_vld_d      = 1'b1;
        id_inst_d     = i_imem_inst;
        id_pc_d       = pc_q;
        id_pc_plus4_d = pc_plus4;
      end else begin
        // The end word itself is never handed to decode.
        id_vld_d = 1'b0;
      end
    end else if (id_vld_q && i_id_ready) begin
      id_vld_d = 1'b0;
    end
  end

  // PC and IF/ID registers; reset discards any in-flight instruction immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q          <= RESET_PC;
      id_vld_q      <= 1'b0;
      id_inst_q     <= NOP_INST;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
    end else begin
      pc_q          <= pc_d;
      id_vld_q      <= id_vld_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  assign o_id_valid    = id_vld_q;
  assign o_id_inst     = id_inst_q;
  assign o_id_pc       = id_pc_q;
  assign o_id_pc_plus4 = id_pc_plus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: program-image model, directed scenarios then randomized ready/redirect traffic.
// Expected per-cycle status and handed-off instructions are queued by the driver, checked by a monitor.
// The monitor samples on the falling edge; the driver changes inputs 1 time unit after the rising edge.
module tb_fetch_stage;

  localparam int ADDR_W = 10;
  localparam int WORDS  = 256;

  typedef struct packed {
    logic        vld;
    logic [9:0]  addr;
    logic        halt;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } st_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_inst;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              id_ready;
  logic              id_valid;
  logic [31:0]       id_inst;
  logic [31:0]       id_pc;
  logic [31:0]       id_pc_plus4;
  logic              halted;

  logic [31:0] mem [WORDS];
  assign imem_inst = mem[imem_addr[ADDR_W-1:2]];

  fetch_stage dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_addr   (imem_addr),
    .i_imem_inst   (imem_inst),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_id_ready    (id_ready),
    .o_id_valid    (id_valid),
    .o_id_inst     (id_inst),
    .o_id_pc       (id_pc),
    .o_id_pc_plus4 (id_pc_plus4),
    .o_halted      (halted)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  st_t  st_q [$];
  ent_t exp_q [$];

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc;
  logic        m_vld;
  logic        m_halt;
  logic [31:0] m_inst, m_ipc, m_ipc4;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_vld  = 1'b0;
    m_halt = 1'b0;
    m_inst = 32'h0000_0013;
    m_ipc  = 32'h0;
    m_ipc4 = 32'h0;
  endtask

  task automatic load_image();
    for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
    mem[0] = 32'h00108113;
    mem[1] = 32'h00108193;
    mem[2] = 32'h00310233;
    mem[3] = 32'hfe218ae3;
    mem[4] = 32'h00000000;
  endtask

  // One clock: apply inputs, record what the DUT must show now, predict the next edge.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
    st_t         s;
    ent_t        e;
    logic [31:0] w;
    id_ready    = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    s.vld  = m_vld;
    s.addr = m_pc[ADDR_W-1:0];
    s.halt = m_halt;
    s.inst = m_inst;
    s.pc   = m_ipc;
    s.pc4  = m_ipc4;
    st_q.push_back(s);
    if (redir) begin
      // A stalled entry is lost; an accepted one is still consumed by decode this cycle.
      if (m_vld && !rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      m_vld  = 1'b0;
      m_halt = 1'b0;
      m_pc   = {rpc[31:2], 2'b00};
    end else if (!m_halt && (!m_vld || rdy)) begin
      w = mem[m_pc[ADDR_W-1:2]];
      if (w != 32'h0) begin
        e.inst = w;
        e.pc   = m_pc;
        e.pc4  = m_pc + 32'd4;
        exp_q.push_back(e);
        m_vld  = 1'b1;
        m_inst = e.inst;
        m_ipc  = e.pc;
        m_ipc4 = e.pc4;
        m_pc   = m_pc + 32'd4;
      end else begin
        m_halt = 1'b1;
        m_vld  = 1'b0;
      end
    end else if (m_halt && rdy) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between edges while decode is stalling; IF/ID must clear at once.
  task automatic reset_mid();
    id_ready = 1'b0;
    redirect = 1'b0;
    #2;
    chk("pre_reset_valid", 32'(id_valid), 32'(m_vld));
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(id_valid), 32'h0);
    chk("async_reset_addr", 32'(imem_addr), 32'h0);
    chk("async_reset_inst", id_inst, 32'h0000_0013);
    chk("async_reset_halted", 32'(halted), 32'h0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: per-cycle status check, plus scoreboard pop on every decode handshake.
  always @(negedge clk) begin
    st_t  s;
    ent_t e;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      chk("id_valid", 32'(id_valid), 32'(s.vld));
      chk("imem_addr", 32'(imem_addr), 32'(s.addr));
      chk("halted", 32'(halted), 32'(s.halt));
      if (s.vld) begin
        chk("held_inst", id_inst, s.inst);
        chk("held_pc", id_pc, s.pc);
        chk("held_pc4", id_pc_plus4, s.pc4);
      end
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL handoff: DUT presented %h at pc %h, expected no instruction", id_inst, id_pc);
        end else begin
          e = exp_q.pop_front();
          chk("handoff_inst", id_inst, e.inst);
          chk("handoff_pc", id_pc, e.pc);
          chk("handoff_pc4", id_pc_plus4, e.pc4);
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    id_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    load_image();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(id_valid), 32'h0);
    chk("reset_inst", id_inst, 32'h0000_0013);
    chk("reset_pc", id_pc, 32'h0);
    chk("reset_pc4", id_pc_plus4, 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);
    chk("reset_addr", 32'(imem_addr), 32'h0);
    rst_n = 1'b1;

    // Straight-line run to the end word, then sit halted.
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    // Redirect out of halt to 0.
    cycle(1'b1, 1'b1, 32'h0);
    // First word loaded, then decode stalls for a while, then resumes.
    cycle(1'b1, 1'b0, 32'h0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    repeat (2) cycle(1'b1, 1'b0, 32'h0);
    // Redirect to an unaligned target while fetching at pc=8.
    cycle(1'b1, 1'b1, 32'h0);
    repeat (2) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_0006);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    // Redirect in the same cycle as a stall drops the stalled entry.
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0004);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    // Asynchronous reset in the middle of a stall.
    cycle(1'b1, 1'b1, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    reset_mid();
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    // PC wrap across 2^32 and across the end of memory.
    mem[WORDS-1] = 32'h1234_5678;
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Randomized images, ready patterns and redirect targets.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom() | 32'h1);
      end
      cycle(1'b1, 1'b1, $urandom());
      for (int i = 0; i < 300; i++) begin
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, $urandom());
        if (i == 150 && ph[0]) reset_mid();
      end
    end

    cycle(1'b1, 1'b0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
